// File: rtl/riscv_pkg.sv
// Shared integer register-file constants and types used by the write-back path.
package riscv_pkg;

   localparam int XLEN     = 32;
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;

   typedef logic [REG_AW-1:0] reg_addr_t;

   localparam reg_addr_t REG_X0 = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first valid requester at or after the pointer wins,
// and the pointer moves just past the winner.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [NUM_REQ-1:0] valid_in,
   output logic [NUM_REQ-1:0] grant_out
);

   localparam int            PW   = $clog2(NUM_REQ);
   localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

   logic [PW-1:0] ptr;
   logic [PW-1:0] idx;
   logic [PW-1:0] win_idx;
   logic          found;

   // NOTE: every output gets a default before the loop, so no path can infer a latch.
   always_comb begin
      grant_out = '0;
      win_idx   = '0;
      idx       = '0;
      found     = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = PW'((int'(ptr) + k) % NUM_REQ);
         if (!found && valid_in[idx]) begin
            found          = 1'b1;
            win_idx        = idx;
            grant_out[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
      end
   end

endmodule

// File: rtl/wb_port_scheduler.sv
// Round-robin sharing of the register-file write port between write-back units,
// with a one-stage commit slot and a per-register busy scoreboard for RAW stalls.
module wb_port_scheduler #(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = riscv_pkg::XLEN,
   parameter int REG_AW  = riscv_pkg::REG_AW
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [NUM_REQ-1:0]        req_valid_in,
   input  logic [NUM_REQ*REG_AW-1:0] req_addr_in,
   input  logic [NUM_REQ*XLEN-1:0]   req_data_in,
   output logic [NUM_REQ-1:0]        req_ready_out,
   input  logic                      issue_en_in,
   input  logic [REG_AW-1:0]         issue_rd_in,
   input  logic [REG_AW-1:0]         rs_1_addr_in,
   input  logic [REG_AW-1:0]         rs_2_addr_in,
   output logic                      rs_1_busy_out,
   output logic                      rs_2_busy_out,
   output logic                      wr_en_out,
   output logic [REG_AW-1:0]         rd_addr_out,
   output logic [XLEN-1:0]           rd_out
);

   import riscv_pkg::*;

   logic [NUM_REQ-1:0]  grant;
   logic                any_grant;
   logic [REG_AW-1:0]   sel_addr;
   logic [XLEN-1:0]     sel_data;
   logic [NUM_REGS-1:0] busy;

   // Nothing is granted while in reset, so no commit can be queued behind it.
   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arbiter (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .valid_in  (req_valid_in & {NUM_REQ{~rst_in}}),
      .grant_out (grant)
   );

   assign req_ready_out = grant;

   always_comb begin
      any_grant = 1'b0;
      sel_addr  = '0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            any_grant = 1'b1;
            sel_addr  = req_addr_in[i*REG_AW +: REG_AW];
            sel_data  = req_data_in[i*XLEN +: XLEN];
         end
      end
   end

   // A grant to x0 still occupies the slot but never raises the write enable.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_en_out   <= 1'b0;
         rd_addr_out <= '0;
         rd_out      <= '0;
      end else begin
         wr_en_out <= any_grant && (sel_addr != REG_X0);
         if (any_grant) begin
            rd_addr_out <= sel_addr;
            rd_out      <= sel_data;
         end
      end
   end

   // NOTE: the busy bits are state that decode relies on, so the whole array is reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         busy <= '0;
      end else begin
         if (wr_en_out) begin
            busy[rd_addr_out] <= 1'b0;
         end
         // NOTE: the later non-blocking write wins, so a new producer overrides a same-cycle clear.
         if (issue_en_in && (issue_rd_in != REG_X0)) begin
            busy[issue_rd_in] <= 1'b1;
         end
         busy[REG_X0] <= 1'b0;
      end
   end

   // The register file forwards a same-cycle write, so a committing register is not busy.
   assign rs_1_busy_out = busy[rs_1_addr_in] & ~(wr_en_out & (rd_addr_out == rs_1_addr_in));
   assign rs_2_busy_out = busy[rs_2_addr_in] & ~(wr_en_out & (rd_addr_out == rs_2_addr_in));

endmodule
